// File: rtl/mem_access_seq_if.sv
// ---------------------------------------------------------------------------
// mem_access_seq_if
// Data-memory bus between the MEM-stage access sequencer and the data memory.
//
// Signals:
//   dmem_read, dmem_write  registered read / write strobes from the sequencer
//   dmem_addr              memory word/byte address
//   dmem_wdata             memory write data
//   dmem_byte_enable       byte lanes: [1] upper byte, [0] lower byte
//   dmem_resp              completion strobe from memory
//   dmem_rdata             read word from memory
//
// Modports:
//   master  the sequencer side (drives strobes, address, data, lanes)
//   slave   the memory side (drives resp and read data)
// ---------------------------------------------------------------------------
interface mem_access_seq_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;

    modport master (
        output dmem_read,
        output dmem_write,
        output dmem_addr,
        output dmem_wdata,
        output dmem_byte_enable,
        input  dmem_resp,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_read,
        input  dmem_write,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_byte_enable,
        output dmem_resp,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_seq.sv
// ---------------------------------------------------------------------------
// mem_access_seq
// LC-3b MEM-stage data-memory access sequencer. Turns a MEM-stage load/store
// control word into registered memory strobes, handles the two-step indirect
// accesses of LDI/STI, formats byte accesses, and stalls the pipeline until
// the access has completed.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   valid      MEM stage holds a live instruction
//   opcode     lc3b opcode of the MEM-stage instruction
//   mem_read   control-word read request
//   mem_write  control-word write request
//   addr       effective address (ALU result or trap vector address)
//   wdata      store source data
//   rdata_out  registered load result for writeback
//   stall      freezes the pipeline up to and including MEM
//   dmem       data-memory bus (master side)
//
// Timing: a strobe state spends its first cycle raising the registered
// strobe, then holds it until dmem_resp. With memory ready in the first
// strobe cycle, a simple access reaches DONE three cycles after the request
// and an indirect access five cycles after it.
// ---------------------------------------------------------------------------
module mem_access_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic [3:0]  opcode,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata_out,
    output logic        stall,
    mem_access_seq_if.master dmem
);

    localparam logic [3:0] OP_LDB = 4'd2;
    localparam logic [3:0] OP_STB = 4'd3;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_STI = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        INDIRECT,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic        is_write_q, is_write_d;
    logic        dmem_read_q, dmem_read_d;
    logic        dmem_write_q, dmem_write_d;
    logic [15:0] dmem_addr_q, dmem_addr_d;
    logic [15:0] dmem_wdata_q, dmem_wdata_d;
    logic [1:0]  dmem_be_q, dmem_be_d;
    logic [15:0] rdata_q, rdata_d;

    logic        strobe_active;
    logic        is_byte_op;
    logic        captured_indirect;
    logic [15:0] load_value;

    assign strobe_active     = dmem_read_q | dmem_write_q;
    assign is_byte_op        = (opcode == OP_LDB) || (opcode == OP_STB);
    assign captured_indirect = (op_q == OP_LDI) || (op_q == OP_STI);

    // Byte loads pick the lane that was enabled and zero-extend it.
    assign load_value = (op_q == OP_LDB)
                      ? (dmem_be_q[1] ? {8'h00, dmem.dmem_rdata[15:8]}
                                      : {8'h00, dmem.dmem_rdata[7:0]})
                      : dmem.dmem_rdata;

    // State and registered outputs. Reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= 4'd0;
            is_write_q   <= 1'b0;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            dmem_addr_q  <= 16'h0000;
            dmem_wdata_q <= 16'h0000;
            dmem_be_q    <= 2'b00;
            rdata_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            is_write_q   <= is_write_d;
            dmem_read_q  <= dmem_read_d;
            dmem_write_q <= dmem_write_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state and stall. Address, data and lanes are formatted at capture
    // time so they stay frozen while the access is in flight. dmem_resp is
    // only honoured while a strobe is actually up.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        is_write_d   = is_write_q;
        dmem_read_d  = dmem_read_q;
        dmem_write_d = dmem_write_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        rdata_d      = rdata_q;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                // A request with both directions set is malformed and dropped.
                if (valid && (mem_read ^ mem_write)) begin
                    stall        = 1'b1;
                    op_d         = opcode;
                    is_write_d   = mem_write;
                    dmem_addr_d  = is_byte_op ? addr : {addr[15:1], 1'b0};
                    dmem_be_d    = is_byte_op ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
                    dmem_wdata_d = (opcode == OP_STB) ? {wdata[7:0], wdata[7:0]} : wdata;
                    state_d      = FIRST;
                end
            end

            FIRST: begin
                stall = 1'b1;
                if (!strobe_active) begin
                    // LDI and STI both fetch the pointer first, so their first
                    // access is always a read.
                    if (captured_indirect || !is_write_q) begin
                        dmem_read_d = 1'b1;
                    end else begin
                        dmem_write_d = 1'b1;
                    end
                end else if (dmem.dmem_resp) begin
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    if (captured_indirect) begin
                        dmem_addr_d = {dmem.dmem_rdata[15:1], 1'b0};
                        dmem_be_d   = 2'b11;
                        state_d     = INDIRECT;
                    end else begin
                        if (!is_write_q) begin
                            rdata_d = load_value;
                        end
                        state_d = DONE;
                    end
                end
            end

            INDIRECT: begin
                stall = 1'b1;
                if (!strobe_active) begin
                    if (op_q == OP_STI) begin
                        dmem_write_d = 1'b1;
                    end else begin
                        dmem_read_d = 1'b1;
                    end
                end else if (dmem.dmem_resp) begin
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    if (op_q != OP_STI) begin
                        rdata_d = dmem.dmem_rdata;
                    end
                    state_d = DONE;
                end
            end

            DONE: begin
                // One released cycle; whatever is presented now is the next
                // instruction's request and is picked up back in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dmem.dmem_read        = dmem_read_q;
    assign dmem.dmem_write       = dmem_write_q;
    assign dmem.dmem_addr        = dmem_addr_q;
    assign dmem.dmem_wdata       = dmem_wdata_q;
    assign dmem.dmem_byte_enable = dmem_be_q;
    assign rdata_out             = rdata_q;

endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port valid  in  1  MEM stage holds a live instruction.
REQ-004 SHALL have port opcode  in  4  lc3b_opcode of the MEM-stage instruction.
REQ-005 SHALL have port mem_read  in  1  control-word read request.
REQ-006 SHALL have port mem_write  in  1  control-word write request.
REQ-007 SHALL have port addr  in  16  effective address (ALU result, or trap vector address).
REQ-008 SHALL have port wdata  in  16  store source data.
REQ-009 SHALL have port dmem_resp  in  1  data memory completion strobe.
REQ-010 SHALL have port dmem_rdata  in  16  data memory read word.
REQ-011 SHALL have port dmem_read / dmem_write  out  1 each  memory strobes, registered.
REQ-012 SHALL have port dmem_addr  out  16  memory address, registered.
REQ-013 SHALL have port dmem_wdata  out  16  memory write data, registered.
REQ-014 SHALL have port dmem_byte_enable  out  2  byte lanes, registered.
REQ-015 SHALL have port rdata_out  out  16  load result for writeback, registered.
REQ-016 SHALL have port stall  out  1  freeze the pipeline upstream of and including MEM.

Function
REQ-017 SHALL implement states IDLE, FIRST, INDIRECT, DONE.
REQ-018 IDLE: valid with exactly one of mem_read/mem_write SHALL capture opcode, addr, wdata and direction, then go to FIRST.
- stall=1 combinationally in that cycle.
REQ-019 valid with both mem_read and mem_write high SHALL be ignored: no access, stall=0, stay IDLE.
REQ-020 FIRST SHALL hold the strobe for the captured direction until dmem_resp; stall=1.
- Address, data and byte enables SHALL be stable throughout.
REQ-021 Word ops (LDR, STR, LDI, STI, TRAP) SHALL drive dmem_addr={addr[15:1],0} and dmem_byte_enable=11.
REQ-022 LDB/STB SHALL drive dmem_addr=addr and dmem_byte_enable = addr[0] ? 10 : 01.
- STB SHALL drive dmem_wdata={wdata[7:0],wdata[7:0]}.
REQ-023 FIRST, dmem_resp, opcode LDI or STI: SHALL go to INDIRECT.
- Address becomes {dmem_rdata[15:1],0}; strobes drop for exactly one cycle before INDIRECT.
- LDI SHALL read in INDIRECT; STI SHALL write wdata in INDIRECT.
REQ-024 FIRST (other opcodes) or INDIRECT, on dmem_resp: SHALL deassert strobes next cycle and go to DONE.
- Loads SHALL latch rdata_out: word ops take dmem_rdata; LDB takes the selected byte zero-extended to 16 bits.
REQ-025 DONE SHALL hold stall=0 for exactly one cycle, keep rdata_out stable, then return to IDLE.
- The request presented during DONE SHALL NOT start a new access.
REQ-026 dmem_resp in IDLE or DONE SHALL be ignored.
REQ-027 Changes on valid/addr/wdata after capture SHALL NOT affect the in-flight access.
REQ-028 Stores SHALL leave rdata_out unchanged.
REQ-029 Latency, memory ready in the first strobe cycle: simple access = 3 cycles request-to-DONE; indirect = 5 cycles.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE and drive to 0: dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable, rdata_out.
- stall SHALL then follow REQ-018 only.
REQ-031 Reset asserted mid-access SHALL abandon the access; no resume after release.

Verification
REQ-032 LDR: addr=0x1235, dmem_resp on first strobe cycle, rdata=0xBEEF -> dmem_addr=0x1234, be=11, stall high 3 cycles, rdata_out=0xBEEF in DONE.
REQ-033 STB: addr=0x2001, wdata=0x00A5 -> dmem_write, be=10, dmem_wdata=0xA5A5; LDB addr=0x2001, rdata=0xA5C3 -> rdata_out=0x00A5.
REQ-034 LDI: addr=0x3000; first rdata=0x4001; second rdata=0x7777 -> second read at 0x4000, rdata_out=0x7777, 5-cycle stall window.
REQ-035 STR, dmem_resp withheld 4 cycles -> dmem_write and addr/data stable all 4 cycles, stall high, single DONE cycle after response.
REQ-036 reset_n pulsed low during STI INDIRECT -> strobes 0 same cycle, IDLE after release, no further write.
REQ-037 mem_read=mem_write=1 with valid -> no strobe, stall=0; spurious dmem_resp in IDLE -> no state change.
